// File: rtl/uart_fifo_mmio.sv
// Memory-mapped 8N1 UART with TX/RX byte FIFOs, run-time baud divisor,
// loopback and a level interrupt, sitting on the data-memory bus.

module uart_fifo_mmio_fifo #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [7:0]    i_din,
  output logic [7:0]    o_dout,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);
  localparam int PW = $clog2(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rd_ptr];
  // A full FIFO still accepts a push when the same cycle pops an entry.
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

module uart_fifo_mmio #(
  parameter int FIFO_DEPTH  = 8,
  parameter int DEFAULT_DIV = 434
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_wr_en,
  input  logic        i_rd_en,
  input  logic [1:0]  i_addr,
  input  logic [31:0] i_wr_data,
  output logic [31:0] o_read_reg,
  input  logic        i_serial_in,
  output logic        o_serial_out,
  output logic        o_irq
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [15:0]   r_div;
  logic          r_rx_irq_en, r_tx_irq_en, r_loopback;
  logic          r_rx_ovf, r_frame_err, r_tx_ovf, r_irq;

  state_t        r_tx_state;
  logic [15:0]   r_tx_div, r_tx_cnt;
  logic [2:0]    r_tx_bit;
  logic [7:0]    r_tx_shift;
  logic          r_tx_out;

  state_t        r_rx_state;
  logic [15:0]   r_rx_div, r_rx_cnt;
  logic [2:0]    r_rx_bit;
  logic [7:0]    r_rx_shift;
  logic          r_sync1, r_sync2;

  logic          w_wr_tx, w_wr_status, w_wr_ctrl, w_rd_rx;
  logic          w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic [CW-1:0] w_tx_count, w_rx_count;
  logic [7:0]    w_tx_head, w_rx_head;
  logic          w_tx_bit_end, w_tx_pop, w_tx_busy;
  logic          w_rx_bit_end, w_rx_half, w_rx_stop, w_rx_push, w_rx_pop;
  logic          w_tx_ovf_set, w_rx_ovf_set, w_frame_err_set;
  logic          w_rx_line;
  logic          w_unused;

  assign w_wr_tx     = i_wr_en & (i_addr == 2'd0);
  assign w_wr_status = i_wr_en & (i_addr == 2'd2);
  assign w_wr_ctrl   = i_wr_en & (i_addr == 2'd3);
  assign w_rd_rx     = i_rd_en & (i_addr == 2'd1);
  assign w_unused    = ^i_wr_data[31:19];

  assign w_tx_bit_end = (r_tx_cnt == r_tx_div - 16'd1);
  assign w_tx_pop     = ~w_tx_empty & ((r_tx_state == S_IDLE) |
                                       ((r_tx_state == S_STOP) & w_tx_bit_end));
  assign w_tx_busy    = (r_tx_state != S_IDLE);

  assign w_rx_line    = r_loopback ? r_tx_out : i_serial_in;
  assign w_rx_bit_end = (r_rx_cnt == r_rx_div - 16'd1);
  assign w_rx_half    = (r_rx_cnt == (r_rx_div >> 1) - 16'd1);
  assign w_rx_stop    = (r_rx_state == S_STOP) & w_rx_bit_end;
  assign w_rx_push    = w_rx_stop & r_sync2;
  assign w_rx_pop     = w_rd_rx & ~w_rx_empty;

  assign w_tx_ovf_set    = w_wr_tx & w_tx_full & ~w_tx_pop;
  assign w_rx_ovf_set    = w_rx_push & w_rx_full & ~w_rx_pop;
  assign w_frame_err_set = w_rx_stop & ~r_sync2;

  uart_fifo_mmio_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_push(w_wr_tx), .i_pop(w_tx_pop),
    .i_din(i_wr_data[7:0]), .o_dout(w_tx_head), .o_full(w_tx_full),
    .o_empty(w_tx_empty), .o_count(w_tx_count)
  );

  uart_fifo_mmio_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_push(w_rx_push), .i_pop(w_rd_rx),
    .i_din(r_rx_shift), .o_dout(w_rx_head), .o_full(w_rx_full),
    .o_empty(w_rx_empty), .o_count(w_rx_count)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div       <= 16'(DEFAULT_DIV);
      r_rx_irq_en <= 1'b0;
      r_tx_irq_en <= 1'b0;
      r_loopback  <= 1'b0;
      r_rx_ovf    <= 1'b0;
      r_frame_err <= 1'b0;
      r_tx_ovf    <= 1'b0;
      r_irq       <= 1'b0;
    end else begin
      if (w_wr_ctrl) begin
        r_div       <= (i_wr_data[15:0] < 16'd4) ? 16'd4 : i_wr_data[15:0];
        r_rx_irq_en <= i_wr_data[16];
        r_tx_irq_en <= i_wr_data[17];
        r_loopback  <= i_wr_data[18];
      end
      // A hardware set in the same cycle as a software clear keeps the bit set.
      if (w_rx_ovf_set)                      r_rx_ovf <= 1'b1;
      else if (w_wr_status & i_wr_data[5])   r_rx_ovf <= 1'b0;
      if (w_frame_err_set)                   r_frame_err <= 1'b1;
      else if (w_wr_status & i_wr_data[6])   r_frame_err <= 1'b0;
      if (w_tx_ovf_set)                      r_tx_ovf <= 1'b1;
      else if (w_wr_status & i_wr_data[7])   r_tx_ovf <= 1'b0;
      r_irq <= (r_rx_irq_en & ~w_rx_empty) | (r_tx_irq_en & w_tx_empty) |
               r_rx_ovf | r_frame_err | r_tx_ovf;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tx_state <= S_IDLE;
      r_tx_div   <= 16'(DEFAULT_DIV);
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx_out   <= 1'b1;
    end else begin
      r_tx_cnt <= w_tx_bit_end ? 16'd0 : r_tx_cnt + 16'd1;
      case (r_tx_state)
        S_IDLE: begin
          r_tx_cnt <= '0;
          if (w_tx_pop) begin
            r_tx_state <= S_START;
            r_tx_div   <= r_div;
            r_tx_shift <= w_tx_head;
            r_tx_out   <= 1'b0;
          end
        end
        S_START: begin
          if (w_tx_bit_end) begin
            r_tx_state <= S_DATA;
            r_tx_bit   <= '0;
            r_tx_out   <= r_tx_shift[0];
          end
        end
        S_DATA: begin
          if (w_tx_bit_end) begin
            if (r_tx_bit == 3'd7) begin
              r_tx_state <= S_STOP;
              r_tx_out   <= 1'b1;
            end else begin
              r_tx_bit   <= r_tx_bit + 3'd1;
              r_tx_shift <= r_tx_shift >> 1;
              r_tx_out   <= r_tx_shift[1];
            end
          end
        end
        default: begin
          // Chain straight into the next start bit when more data is queued.
          if (w_tx_bit_end) begin
            if (w_tx_pop) begin
              r_tx_state <= S_START;
              r_tx_div   <= r_div;
              r_tx_shift <= w_tx_head;
              r_tx_out   <= 1'b0;
            end else begin
              r_tx_state <= S_IDLE;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_rx_state <= S_IDLE;
      r_rx_div   <= 16'(DEFAULT_DIV);
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
    end else begin
      r_sync1  <= w_rx_line;
      r_sync2  <= r_sync1;
      r_rx_cnt <= r_rx_cnt + 16'd1;
      case (r_rx_state)
        S_IDLE: begin
          r_rx_cnt <= '0;
          if (!r_sync2) begin
            r_rx_state <= S_START;
            r_rx_div   <= r_div;
          end
        end
        S_START: begin
          // Mid-start-bit check rejects short glitches on the line.
          if (w_rx_half) begin
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_state <= r_sync2 ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (w_rx_bit_end) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {r_sync2, r_rx_shift[7:1]};
            r_rx_bit   <= r_rx_bit + 3'd1;
            if (r_rx_bit == 3'd7) r_rx_state <= S_STOP;
          end
        end
        default: begin
          if (w_rx_bit_end) r_rx_state <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    o_read_reg = '0;
    case (i_addr)
      2'd1:    o_read_reg = {22'd0, ~w_rx_empty, 1'b0, w_rx_head & {8{~w_rx_empty}}};
      2'd2:    o_read_reg = {8'd0, 8'(w_tx_count), 8'(w_rx_count), r_tx_ovf, r_frame_err,
                             r_rx_ovf, w_tx_busy, w_rx_full, w_rx_empty, w_tx_empty, w_tx_full};
      2'd3:    o_read_reg = {13'd0, r_loopback, r_tx_irq_en, r_rx_irq_en, r_div};
      default: o_read_reg = '0;
    endcase
  end

  assign o_serial_out = r_tx_out;
  assign o_irq        = r_irq;
endmodule

// File: tb/tb_uart_fifo_mmio.sv
// Randomised self-checking bench for uart_fifo_mmio against a queue-based
// model of the register map, FIFOs and the 8N1 line format.

module tb_uart_fifo_mmio;
  localparam int DIV   = 16;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] wr_data = 32'd0;
  logic        serial_in = 1'b1;
  wire  [31:0] read_reg;
  wire         serial_out;
  wire         irq;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  uart_fifo_mmio #(.FIFO_DEPTH(DEPTH), .DEFAULT_DIV(DIV)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_rd_en(rd_en),
    .i_addr(addr), .i_wr_data(wr_data), .o_read_reg(read_reg),
    .i_serial_in(serial_in), .o_serial_out(serial_out), .o_irq(irq)
  );

  initial begin
    #500us;
    $display("FAIL watchdog: simulation still running at 500us, required completion");
    $fatal(1);
  end

  function automatic logic [31:0] exp_status(int txc, int rxc, bit busy, bit rxo, bit fe, bit txo);
    logic [7:0] t;
    logic [7:0] r;
    t = txc[7:0];
    r = rxc[7:0];
    return {8'h00, t, r, txo, fe, rxo, busy, (rxc == DEPTH), (rxc == 0), (txc == 0), (txc == DEPTH)};
  endfunction

  // Line level of bit slot k in an 8N1 frame: start, 8 data LSB first, stop.
  function automatic logic frame_bit(logic [7:0] b, int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    return 1'b1;
  endfunction

  // Bus tasks start and end on a falling edge so writes can run back to back.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    wr_en = 1'b1; addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, input bit pop, output logic [31:0] d);
    addr = a; rd_en = pop;
    #1 d = read_reg;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic drive_rx(input logic [7:0] b, input bit stop_ok);
    for (int k = 0; k < 10; k++) begin
      serial_in = (k == 9) ? stop_ok : frame_bit(b, k);
      repeat ((k == 9 && !stop_ok) ? 12 : DIV) @(negedge clk);
    end
    serial_in = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (serial_out !== 1'b1 || irq !== 1'b0) begin failures++;
      $display("FAIL reset_lines: serial_out=%b irq=%b required 1 0", serial_out, irq); end
    bus_read(2'd2, 0, d);
    checks++; if (d !== exp_status(0, 0, 0, 0, 0, 0)) begin failures++;
      $display("FAIL reset_status: got %h required %h", d, exp_status(0, 0, 0, 0, 0, 0)); end
    bus_read(2'd3, 0, d);
    checks++; if (d !== DIV) begin failures++;
      $display("FAIL reset_ctrl: got %h required %h", d, DIV); end
    bus_read(2'd1, 1, d);
    checks++; if (d !== 32'd0) begin failures++;
      $display("FAIL reset_rxdata: got %h required 0", d); end
  endtask

  task automatic test_tx_frame();
    logic [7:0] b = 8'hA5;
    int bad = 0;
    int first = -1;
    bit found = 0;
    bus_write(2'd0, {24'd0, b});
    addr = 2'd2;
    for (int i = 0; i < 5 && !found; i++) begin
      @(negedge clk);
      if (serial_out === 1'b0) found = 1;
    end
    checks++; if (!found) begin failures++;
      $display("FAIL tx_start: serial_out stayed high, required low within 5 cycles"); end
    else begin
      for (int i = 0; i < 10 * DIV; i++) begin
        if (i > 0) @(negedge clk);
        if (serial_out !== frame_bit(b, i / DIV) || read_reg[4] !== 1'b1) begin
          bad++; if (first < 0) first = i;
        end
      end
      checks++; if (bad != 0) begin failures++;
        $display("FAIL tx_wave: %0d bad cycles (first %0d), required 0", bad, first); end
      @(negedge clk);
      checks++; if (serial_out !== 1'b1 || read_reg[4] !== 1'b0) begin failures++;
        $display("FAIL tx_idle: serial_out=%b busy=%b required 1 0", serial_out, read_reg[4]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes[6];
    logic [7:0] sent[$];
    logic [7:0] q[$];
    bit ovf = 0;
    logic [31:0] d;
    int bad = 0;
    int first = -1;
    bit found = 0;
    for (int i = 0; i < 6; i++) bytes[i] = 8'($urandom);
    // Byte 0 leaves the FIFO for the shifter right away; the rest queue up.
    sent.push_back(bytes[0]);
    for (int i = 1; i < 6; i++) begin
      if (q.size() < DEPTH) q.push_back(bytes[i]); else ovf = 1;
    end
    foreach (q[i]) sent.push_back(q[i]);
    bus_write(2'd0, {24'd0, bytes[0]});
    fork
      begin
        for (int i = 0; i < 5 && !found; i++) begin
          @(negedge clk);
          if (serial_out === 1'b0) found = 1;
        end
        checks++; if (!found) begin failures++;
          $display("FAIL b2b_start: serial_out stayed high, required low"); end
        else begin
          for (int i = 0; i < sent.size() * 10 * DIV; i++) begin
            if (i > 0) @(negedge clk);
            if (serial_out !== frame_bit(sent[i / (10 * DIV)], (i % (10 * DIV)) / DIV)) begin
              bad++; if (first < 0) first = i;
            end
          end
          @(negedge clk);
          checks++; if (bad != 0 || serial_out !== 1'b1) begin failures++;
            $display("FAIL b2b_wave: %0d bad cycles (first %0d) end=%b, required 0 and 1",
                     bad, first, serial_out); end
        end
      end
      begin
        repeat (4) @(negedge clk);
        for (int i = 1; i < 6; i++) bus_write(2'd0, {24'd0, bytes[i]});
        bus_read(2'd2, 0, d);
        checks++; if (d !== exp_status(q.size(), 0, 1, 0, 0, ovf)) begin failures++;
          $display("FAIL b2b_status: got %h required %h", d, exp_status(q.size(), 0, 1, 0, 0, ovf)); end
      end
    join
    bus_write(2'd2, 32'h80);
    bus_read(2'd2, 0, d);
    checks++; if (d !== exp_status(0, 0, 0, 0, 0, 0)) begin failures++;
      $display("FAIL tx_ovf_clear: got %h required %h", d, exp_status(0, 0, 0, 0, 0, 0)); end
  endtask

  task automatic test_rx();
    logic [31:0] d;
    logic [7:0] q[$];
    bit ovf = 0;
    logic [7:0] b;
    drive_rx(8'h3C, 1);
    bus_read(2'd1, 0, d);
    checks++; if (d !== 32'h23C) begin failures++; $display("FAIL rx_peek: got %h required 23c", d); end
    bus_read(2'd1, 1, d);
    checks++; if (d !== 32'h23C) begin failures++; $display("FAIL rx_pop: got %h required 23c", d); end
    bus_read(2'd1, 0, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL rx_after_pop: got %h required 0", d); end
    for (int i = 0; i < DEPTH + 1; i++) begin
      b = 8'($urandom);
      drive_rx(b, 1);
      if (q.size() < DEPTH) q.push_back(b); else ovf = 1;
    end
    bus_read(2'd2, 0, d);
    checks++; if (d !== exp_status(0, q.size(), 0, ovf, 0, 0)) begin failures++;
      $display("FAIL rx_full_status: got %h required %h", d, exp_status(0, q.size(), 0, ovf, 0, 0)); end
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL rx_ovf_irq: got %b required 1", irq); end
    while (q.size() > 0) begin
      b = q.pop_front();
      bus_read(2'd1, 1, d);
      checks++; if (d !== {22'd0, 2'b10, b}) begin failures++;
        $display("FAIL rx_data: got %h required %h", d, {22'd0, 2'b10, b}); end
    end
    bus_write(2'd2, 32'h20);
    @(negedge clk);
    bus_read(2'd2, 0, d);
    checks++; if (d !== exp_status(0, 0, 0, 0, 0, 0) || irq !== 1'b0) begin failures++;
      $display("FAIL rx_ovf_clear: got %h irq=%b required %h irq=0", d, irq, exp_status(0, 0, 0, 0, 0, 0)); end
  endtask

  task automatic test_loopback();
    logic [31:0] d;
    logic [7:0] q[$];
    logic [7:0] b;
    bus_write(2'd3, 32'h0004_0002);
    bus_read(2'd3, 0, d);
    checks++; if (d !== 32'h0004_0004) begin failures++;
      $display("FAIL ctrl_min_div: got %h required 00040004", d); end
    serial_in = 1'b0;
    q.push_back(8'h81);
    for (int i = 0; i < 3; i++) q.push_back(8'($urandom));
    foreach (q[i]) bus_write(2'd0, {24'd0, q[i]});
    repeat (200) @(negedge clk);
    bus_read(2'd2, 0, d);
    checks++; if (d !== exp_status(0, q.size(), 0, 0, 0, 0)) begin failures++;
      $display("FAIL loop_status: got %h required %h", d, exp_status(0, q.size(), 0, 0, 0, 0)); end
    while (q.size() > 0) begin
      b = q.pop_front();
      bus_read(2'd1, 1, d);
      checks++; if (d !== {22'd0, 2'b10, b}) begin failures++;
        $display("FAIL loop_data: got %h required %h", d, {22'd0, 2'b10, b}); end
    end
    serial_in = 1'b1;
    repeat (4) @(negedge clk);
    bus_write(2'd3, DIV);
  endtask

  task automatic test_frame_err();
    logic [31:0] d;
    logic [7:0] b = 8'($urandom);
    drive_rx(b, 0);
    bus_read(2'd2, 0, d);
    checks++; if (d !== exp_status(0, 0, 0, 0, 1, 0)) begin failures++;
      $display("FAIL frame_err: got %h required %h", d, exp_status(0, 0, 0, 0, 1, 0)); end
    bus_write(2'd2, 32'h40);
    bus_read(2'd2, 0, d);
    checks++; if (d !== exp_status(0, 0, 0, 0, 0, 0)) begin failures++;
      $display("FAIL frame_err_clear: got %h required %h", d, exp_status(0, 0, 0, 0, 0, 0)); end
    b = 8'($urandom);
    drive_rx(b, 1);
    bus_read(2'd1, 1, d);
    checks++; if (d !== {22'd0, 2'b10, b}) begin failures++;
      $display("FAIL rx_recover: got %h required %h", d, {22'd0, 2'b10, b}); end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    logic [7:0] b = 8'($urandom);
    bus_write(2'd3, 32'h0002_0000 | DIV);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_lag: got %b required 0", irq); end
    @(negedge clk);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_tx_empty: got %b required 1", irq); end
    bus_write(2'd3, 32'h0001_0000 | DIV);
    @(negedge clk);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_rx_empty: got %b required 0", irq); end
    drive_rx(b, 1);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_rx_data: got %b required 1", irq); end
    bus_read(2'd1, 1, d);
    @(negedge clk);
    checks++; if (irq !== 1'b0 || d !== {22'd0, 2'b10, b}) begin failures++;
      $display("FAIL irq_rx_pop: irq=%b data=%h required 0 %h", irq, d, {22'd0, 2'b10, b}); end
    bus_write(2'd3, DIV);
  endtask

  task automatic test_glitch_and_reset();
    logic [31:0] d;
    serial_in = 1'b0;
    repeat (2) @(negedge clk);
    serial_in = 1'b1;
    repeat (30) @(negedge clk);
    bus_read(2'd2, 0, d);
    checks++; if (d !== exp_status(0, 0, 0, 0, 0, 0)) begin failures++;
      $display("FAIL glitch: got %h required %h", d, exp_status(0, 0, 0, 0, 0, 0)); end
    bus_write(2'd3, 32'h0001_0020);
    bus_write(2'd0, 32'h00);
    bus_write(2'd0, 32'h55);
    bus_write(2'd0, 32'h66);
    repeat (40) @(negedge clk);
    checks++; if (serial_out !== 1'b0) begin failures++;
      $display("FAIL mid_tx_low: serial_out=%b required 0", serial_out); end
    rst_n = 1'b0;
    #1;
    checks++; if (serial_out !== 1'b1) begin failures++;
      $display("FAIL rst_serial_out: got %b required 1", serial_out); end
    @(negedge clk);
    rst_n = 1'b1;
    bus_read(2'd2, 0, d);
    checks++; if (d !== exp_status(0, 0, 0, 0, 0, 0) || irq !== 1'b0) begin failures++;
      $display("FAIL rst_status: got %h irq=%b required %h irq=0", d, irq, exp_status(0, 0, 0, 0, 0, 0)); end
    bus_read(2'd3, 0, d);
    checks++; if (d !== DIV) begin failures++; $display("FAIL rst_ctrl: got %h required %h", d, DIV); end
    repeat (40) @(negedge clk);
    checks++; if (serial_out !== 1'b1) begin failures++;
      $display("FAIL rst_fifo_lost: serial_out=%b required 1", serial_out); end
  endtask

  initial begin
    test_reset();
    test_tx_frame();
    test_back_to_back();
    test_rx();
    test_loopback();
    test_frame_err();
    test_irq();
    test_glitch_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
